// File: rtl/usr_shift_engine_pkg.sv
// Shared types for the universal shift engine.
// Defining USR_ROTATE_EN makes ROL/ROR legal operations.
package usr_shift_pkg;

    typedef enum logic [2:0] {
        USR_NOP  = 3'd0,
        USR_LOAD = 3'd1,
        USR_SHL  = 3'd2,
        USR_SHR  = 3'd3,
        USR_ROL  = 3'd4,
        USR_ROR  = 3'd5
    } usr_op_e;

    typedef enum logic {
        USR_IDLE  = 1'b0,
        USR_SHIFT = 1'b1
    } usr_state_e;

    // Opcodes 6/7 are reserved; rotates are only legal when the rotate path is built.
    function automatic logic op_is_legal(input logic [2:0] op);
`ifdef USR_ROTATE_EN
        return (op <= 3'd5);
`else
        return (op <= 3'd3);
`endif
    endfunction

endpackage

// File: rtl/usr_shift_engine_if.sv
// Command/response bundle between a controlling FSM and the shift engine.
interface usr_shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] load_data;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out_l;
    logic             ser_out_r;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, load_data, ser_in,
        input  cmd_ready, q, ser_out_l, ser_out_r, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, load_data, ser_in,
        output cmd_ready, q, ser_out_l, ser_out_r, busy, done, err
    );
endinterface

// File: rtl/usr_shift_engine_ctr.sv
// Remaining-shift down-counter; last_o marks the final pending shift.
module usr_shift_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/usr_shift_engine.sv
// Universal shift register: parallel load, one-position-per-cycle shifts.
// Defining USR_ROTATE_EN adds the ROL/ROR datapath.
module usr_shift_engine
    import usr_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    usr_shift_engine_if.slave  bus
);
    usr_state_e       state_q, state_d;
    usr_op_e          op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] amt_n;
    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_last;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input usr_op_e          op,
                                                   input logic             s);
        case (op)
            USR_SHL: return {v[WIDTH-2:0], s};
            USR_SHR: return {s, v[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            USR_ROL: return {v[WIDTH-2:0], v[WIDTH-1]};
            USR_ROR: return {v[0], v[WIDTH-1:1]};
`endif
            default: return v;
        endcase
    endfunction

    assign amt_n = (bus.cmd_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cmd_amt;

    // The accept edge performs the first shift, so the counter holds N-1.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        q_d      = q_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        if (state_q == USR_SHIFT) begin
            q_d     = shift_one(q_q, op_q, bus.ser_in);
            ctr_dec = 1'b1;
            if (ctr_last) begin
                state_d = USR_IDLE;
                done_d  = 1'b1;
            end
        end else if (bus.cmd_valid) begin
            done_d = 1'b1;
            if (!op_is_legal(bus.cmd_op)) begin
                err_d = 1'b1;
            end else begin
                case (bus.cmd_op)
                    USR_LOAD: q_d = bus.load_data;
                    USR_SHL, USR_SHR, USR_ROL, USR_ROR: begin
                        if (amt_n != '0) begin
                            q_d = shift_one(q_q, usr_op_e'(bus.cmd_op), bus.ser_in);
                            if (amt_n > CNT_W'(1)) begin
                                state_d  = USR_SHIFT;
                                op_d     = usr_op_e'(bus.cmd_op);
                                ctr_load = 1'b1;
                                done_d   = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= USR_IDLE;
            op_q    <= USR_NOP;
            q_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    usr_shift_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (amt_n - CNT_W'(1)),
        .dec_i      (ctr_dec),
        .last_o     (ctr_last)
    );

    assign bus.cmd_ready = (state_q == USR_IDLE);
    assign bus.busy      = (state_q == USR_SHIFT);
    assign bus.q         = q_q;
    assign bus.ser_out_l = q_q[WIDTH-1];
    assign bus.ser_out_r = q_q[0];
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_usr_shift_engine.sv
// Scoreboard bench for usr_shift_engine (WIDTH=8); honours USR_ROTATE_EN.
module tb_usr_shift_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] q;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    usr_shift_engine_if #(.WIDTH(8)) bus ();

    usr_shift_engine #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("q", 32'(bus.q), 32'(mon_e.q));
                chk("err", 32'(bus.err), 32'(mon_e.err));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("ser_out_l", 32'(bus.ser_out_l), 32'(mon_e.q[7]));
                chk("ser_out_r", 32'(bus.ser_out_r), 32'(mon_e.q[0]));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] data,
                         input logic ser, input logic [7:0] eq, input logic ee, input int lat,
                         input bit push, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_amt   = amt;
        bus.load_data = data;
        bus.ser_in    = ser;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) sb.push_back('{q: eq, err: ee, cyc: acc + lat - 1});
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int a0, a1, w;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_amt   = 4'd0;
        bus.load_data = 8'h00;
        bus.ser_in    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LOAD then a 3-position left shift filling with ones
        issue(3'd1, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1, 1'b1, a0);
        issue(3'd2, 4'd3, 8'h00, 1'b1, 8'h2F, 1'b0, 3, 1'b1, a0);
        chk("shl_busy_c1", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk("shl_busy_c2", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk("shl_busy_c3", 32'(bus.busy), 32'd0);

        // Zero amount, then an over-range amount clamped to WIDTH
        issue(3'd1, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1, 1'b1, a0);
        issue(3'd3, 4'd0, 8'h00, 1'b0, 8'h81, 1'b0, 1, 1'b1, a0);
        issue(3'd3, 4'd15, 8'h00, 1'b0, 8'h00, 1'b0, 8, 1'b1, a0);

        // Rotates and reserved opcode
        issue(3'd1, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1, 1'b1, a0);
`ifdef USR_ROTATE_EN
        issue(3'd4, 4'd1, 8'h00, 1'b0, 8'h03, 1'b0, 1, 1'b1, a0);
        issue(3'd7, 4'd3, 8'hFF, 1'b1, 8'h03, 1'b1, 1, 1'b1, a0);
        issue(3'd5, 4'd2, 8'h00, 1'b0, 8'hC0, 1'b0, 2, 1'b1, a0);
        issue(3'd4, 4'd8, 8'h00, 1'b0, 8'hC0, 1'b0, 8, 1'b1, a0);
`else
        issue(3'd4, 4'd1, 8'h00, 1'b0, 8'h81, 1'b1, 1, 1'b1, a0);
        issue(3'd7, 4'd3, 8'hFF, 1'b1, 8'h81, 1'b1, 1, 1'b1, a0);
        issue(3'd5, 4'd2, 8'h00, 1'b0, 8'h81, 1'b1, 1, 1'b1, a0);
        issue(3'd6, 4'd8, 8'h00, 1'b0, 8'h81, 1'b1, 1, 1'b1, a0);
`endif
        issue(3'd0, 4'd5, 8'h00, 1'b1, (`ifdef USR_ROTATE_EN 8'hC0 `else 8'h81 `endif), 1'b0, 1, 1'b1, a0);

        // Back-to-back: SHR accepted in the LOAD done cycle
        issue(3'd1, 4'd0, 8'h0F, 1'b0, 8'h0F, 1'b0, 1, 1'b1, a0);
        issue(3'd3, 4'd2, 8'h00, 1'b0, 8'h03, 1'b0, 2, 1'b1, a1);
        chk("no_bubble", 32'(a1), 32'(a0 + 1));

        // Full-width fill and a single shift
        issue(3'd2, 4'd8, 8'h00, 1'b1, 8'hFF, 1'b0, 8, 1'b1, a0);
        issue(3'd2, 4'd1, 8'h00, 1'b0, 8'hFE, 1'b0, 1, 1'b1, a0);

        // Reset in the middle of a long shift
        issue(3'd3, 4'd8, 8'h00, 1'b0, 8'h00, 1'b0, 8, 1'b0, a0);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        chk("mid_q", 32'(bus.q), 32'h7F);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_q", 32'(bus.q), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        issue(3'd1, 4'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1, 1'b1, a0);

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        repeat (12) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
